// File: rtl/arc4_encrypt.sv
// rtl/arc4_encrypt.sv - ARC4 encryptor: length-prefixed plaintext RAM to ciphertext RAM
module arc4_encrypt #(
    parameter int KEY_BYTES = 3,
    parameter int MAX_LEN   = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [KEY_BYTES*8-1:0] key,
    output logic [7:0]             s_addr,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [7:0]             ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren
);
    localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [7:0] MAX_L = 8'(MAX_LEN);
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT,
        S_KSA_RI, S_KSA_RJ, S_KSA_WI, S_KSA_WJ,
        S_LEN_RD, S_LEN_WR,
        S_PRGA_RI, S_PRGA_RJ, S_PRGA_WI, S_PRGA_WJ, S_PRGA_PAD, S_PRGA_XOR,
        S_DONE
    } state_t;

    state_t                  state, state_n;
    logic [7:0]              i, i_n, j, j_n, k, k_n, len, len_n;
    logic [7:0]              si, si_n, sj, sj_n;
    logic [KIDX_W-1:0]       kidx, kidx_n;
    logic [KEY_BYTES*8-1:0]  key_q, key_n;
    logic [7:0]              key_byte;
    logic [7:0]              len_v;

    // Byte 0 of the key is the most significant byte
    always_comb begin
        key_byte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (kidx == KIDX_W'(b)) key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            len   <= '0;
            si    <= '0;
            sj    <= '0;
            kidx  <= '0;
            key_q <= '0;
        end else begin
            state <= state_n;
            i     <= i_n;
            j     <= j_n;
            k     <= k_n;
            len   <= len_n;
            si    <= si_n;
            sj    <= sj_n;
            kidx  <= kidx_n;
            key_q <= key_n;
        end
    end

    always_comb begin
        state_n   = state;
        i_n       = i;
        j_n       = j;
        k_n       = k;
        len_n     = len;
        si_n      = si;
        sj_n      = sj;
        kidx_n    = kidx;
        key_n     = key_q;
        len_v     = '0;
        rdy       = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        pt_addr   = '0;
        ct_addr   = '0;
        ct_wrdata = '0;
        ct_wren   = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                rdy     = 1'b1;
                state_n = S_IDLE;
                if (en) begin
                    state_n = S_INIT;
                    key_n   = key;
                    i_n     = '0;
                    j_n     = '0;
                    k_n     = '0;
                end
            end
            S_INIT: begin
                s_addr   = i;
                s_wrdata = i;
                s_wren   = 1'b1;
                i_n      = i + 8'd1;
                if (i == 8'hFF) begin
                    state_n = S_KSA_RI;
                    j_n     = '0;
                    kidx_n  = '0;
                end
            end
            S_KSA_RI: begin
                s_addr  = i;
                state_n = S_KSA_RJ;
            end
            S_KSA_RJ: begin
                si_n    = s_rddata;
                j_n     = j + s_rddata + key_byte;
                s_addr  = j_n;
                state_n = S_KSA_WI;
            end
            // Swap writes use the latched reads so i==j leaves S untouched
            S_KSA_WI: begin
                sj_n     = s_rddata;
                s_addr   = i;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
                state_n  = S_KSA_WJ;
            end
            S_KSA_WJ: begin
                s_addr   = j;
                s_wrdata = si;
                s_wren   = 1'b1;
                i_n      = i + 8'd1;
                kidx_n   = (kidx == KIDX_LAST) ? '0 : kidx + 1'b1;
                state_n  = (i == 8'hFF) ? S_LEN_RD : S_KSA_RI;
            end
            S_LEN_RD: begin
                pt_addr = '0;
                state_n = S_LEN_WR;
            end
            S_LEN_WR: begin
                len_v     = (pt_rddata > MAX_L) ? MAX_L : pt_rddata;
                ct_addr   = '0;
                ct_wrdata = len_v;
                ct_wren   = 1'b1;
                len_n     = len_v;
                i_n       = '0;
                j_n       = '0;
                k_n       = 8'd1;
                state_n   = (len_v == 8'd0) ? S_DONE : S_PRGA_RI;
            end
            S_PRGA_RI: begin
                i_n     = i + 8'd1;
                s_addr  = i_n;
                state_n = S_PRGA_RJ;
            end
            S_PRGA_RJ: begin
                si_n    = s_rddata;
                j_n     = j + s_rddata;
                s_addr  = j_n;
                state_n = S_PRGA_WI;
            end
            S_PRGA_WI: begin
                sj_n     = s_rddata;
                s_addr   = i;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
                state_n  = S_PRGA_WJ;
            end
            S_PRGA_WJ: begin
                s_addr   = j;
                s_wrdata = si;
                s_wren   = 1'b1;
                state_n  = S_PRGA_PAD;
            end
            // Post-swap S[i]+S[j] equals the pre-swap sum, so latched values suffice
            S_PRGA_PAD: begin
                s_addr  = si + sj;
                pt_addr = k;
                state_n = S_PRGA_XOR;
            end
            S_PRGA_XOR: begin
                ct_addr   = k;
                ct_wrdata = pt_rddata ^ s_rddata;
                ct_wren   = 1'b1;
                if (k == len) begin
                    state_n = S_DONE;
                end else begin
                    k_n     = k + 8'd1;
                    state_n = S_PRGA_RI;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_arc4_encrypt.sv
// tb/tb_arc4_encrypt.sv - self-checking bench for arc4_encrypt
module tb_arc4_encrypt;
    logic        clk, rst_n;
    logic        en, en2, rdy, rdy2;
    logic [23:0] key;
    logic [7:0]  s_addr, s_rddata, s_wrdata, pt_addr, pt_rddata, ct_addr, ct_wrdata;
    logic        s_wren, ct_wren;
    logic [7:0]  s_addr2, s_rddata2, s_wrdata2, pt_addr2, pt_rddata2, ct_addr2, ct_wrdata2;
    logic        s_wren2, ct_wren2;

    logic [7:0]  s_mem [256];
    logic [7:0]  s_mem2[256];
    logic [7:0]  pt_mem[256];
    logic [7:0]  exp_ct[256];
    logic [15:0] ct_log[$];
    logic [15:0] ct_log2[$];
    int          pt_max, pt_max2, cyc, last_wr_cyc, rdy_cyc;
    int          tests = 0, failed = 0;

    logic [7:0] kv_pt[10] = '{8'd9, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] kv_ct[10] = '{8'd9, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    localparam logic [23:0] KV_KEY = 24'h4B6579;

    arc4_encrypt dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
        .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .pt_addr(pt_addr), .pt_rddata(pt_rddata),
        .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
    );

    arc4_encrypt #(.KEY_BYTES(3), .MAX_LEN(4)) dut_clamp (
        .clk(clk), .rst_n(rst_n), .en(en2), .rdy(rdy2), .key(key),
        .s_addr(s_addr2), .s_rddata(s_rddata2), .s_wrdata(s_wrdata2), .s_wren(s_wren2),
        .pt_addr(pt_addr2), .pt_rddata(pt_rddata2),
        .ct_addr(ct_addr2), .ct_wrdata(ct_wrdata2), .ct_wren(ct_wren2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        s_rddata   <= s_mem[s_addr];
        s_rddata2  <= s_mem2[s_addr2];
        pt_rddata  <= pt_mem[pt_addr];
        pt_rddata2 <= pt_mem[pt_addr2];
        if (s_wren)  s_mem[s_addr]   <= s_wrdata;
        if (s_wren2) s_mem2[s_addr2] <= s_wrdata2;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (ct_wren) begin
                ct_log.push_back({ct_addr, ct_wrdata});
                last_wr_cyc = cyc;
            end
            if (ct_wren2) ct_log2.push_back({ct_addr2, ct_wrdata2});
            if (int'(pt_addr) > pt_max) pt_max = int'(pt_addr);
            if (int'(pt_addr2) > pt_max2) pt_max2 = int'(pt_addr2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain ARC4 over pt_mem; fills exp_ct and returns the number of ct writes
    function automatic int model_run(input logic [23:0] kk, input int maxl);
        int s[256];
        int kb[3];
        int i, j, l, t;
        kb[0] = int'(kk[23:16]);
        kb[1] = int'(kk[15:8]);
        kb[2] = int'(kk[7:0]);
        for (int a = 0; a < 256; a++) s[a] = a;
        j = 0;
        for (int a = 0; a < 256; a++) begin
            j = (j + s[a] + kb[a % 3]) % 256;
            t = s[a]; s[a] = s[j]; s[j] = t;
        end
        l = (int'(pt_mem[0]) > maxl) ? maxl : int'(pt_mem[0]);
        exp_ct[0] = 8'(l);
        i = 0;
        j = 0;
        for (int n = 1; n <= l; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            exp_ct[n] = pt_mem[n] ^ 8'(s[(s[i] + s[j]) % 256]);
        end
        return l + 1;
    endfunction

    task automatic load_kv();
        for (int x = 0; x < 10; x++) pt_mem[x] = kv_pt[x];
    endtask

    task automatic set_kv_exp();
        for (int x = 0; x < 10; x++) exp_ct[x] = kv_ct[x];
    endtask

    task automatic start_dut(input logic [23:0] kk);
        ct_log.delete();
        pt_max = 0;
        @(negedge clk);
        key = kk;
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (!rdy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        rdy_cyc = cyc;
        chk({tag, "_done"}, {31'd0, rdy}, 32'd1);
    endtask

    task automatic check_log(input string tag, input int n);
        chk({tag, "_count"}, ct_log.size(), n);
        for (int x = 0; x < n && x < ct_log.size(); x++) begin
            chk($sformatf("%s_addr%0d", tag, x), {24'd0, ct_log[x][15:8]}, x);
            chk($sformatf("%s_data%0d", tag, x), {24'd0, ct_log[x][7:0]}, {24'd0, exp_ct[x]});
        end
    endtask

    initial begin
        int n, len;
        logic [23:0] rk;
        rst_n = 1'b0; en = 1'b0; en2 = 1'b0; key = '0; cyc = 0;
        last_wr_cyc = 0; rdy_cyc = 0; pt_max = 0; pt_max2 = 0;
        for (int a = 0; a < 256; a++) pt_mem[a] = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", {31'd0, rdy}, 32'd1);
        chk("rst_s_wren", {31'd0, s_wren}, 32'd0);
        chk("rst_ct_wren", {31'd0, ct_wren}, 32'd0);
        chk("rst_addrs", {8'd0, s_addr, pt_addr, ct_addr}, 32'd0);
        chk("rst_wrdata", {16'd0, s_wrdata, ct_wrdata}, 32'd0);
        rst_n = 1'b1;

        // Known vector
        load_kv();
        start_dut(KV_KEY);
        chk("kv_busy", {31'd0, rdy}, 32'd0);
        wait_rdy("kv");
        set_kv_exp();
        check_log("kv", 10);
        chk("kv_rdy_lat", rdy_cyc - last_wr_cyc, 32'd1);
        chk("kv_pt_max", {31'd0, pt_max <= 9}, 32'd1);

        // Zero length
        pt_mem[0] = 8'd0;
        start_dut(24'hA5C3E1);
        wait_rdy("zero");
        exp_ct[0] = 8'd0;
        check_log("zero", 1);
        chk("zero_pt_max", pt_max, 32'd0);

        // Round trip
        for (int x = 0; x < 4; x++) pt_mem[x] = (x == 0) ? 8'd3 : 8'd0;
        start_dut(24'h000000);
        wait_rdy("rt1");
        n = model_run(24'h000000, 255);
        check_log("rt1", n);
        for (int x = 0; x < 4 && x < ct_log.size(); x++) pt_mem[x] = ct_log[x][7:0];
        start_dut(24'h000000);
        wait_rdy("rt2");
        for (int x = 0; x < 4; x++) exp_ct[x] = (x == 0) ? 8'd3 : 8'd0;
        check_log("rt2", 4);

        // en and key churn while busy
        load_kv();
        start_dut(KV_KEY);
        for (int c = 0; c < 1300; c++) begin
            @(negedge clk);
            en  = 1'($urandom_range(0, 1));
            key = 24'($urandom);
        end
        en = 1'b0;
        wait_rdy("churn");
        set_kv_exp();
        check_log("churn", 10);

        // en held high: back-to-back runs
        ct_log.delete();
        @(negedge clk);
        key = KV_KEY;
        en  = 1'b1;
        @(negedge clk);
        wait_rdy("hold1");
        check_log("hold1", 10);
        ct_log.delete();
        @(negedge clk);
        chk("hold_restart", {31'd0, rdy}, 32'd0);
        en = 1'b0;
        wait_rdy("hold2");
        check_log("hold2", 10);

        // Reset during PRGA byte 4
        start_dut(KV_KEY);
        n = 0;
        while (ct_log.size() < 4 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach", ct_log.size(), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("midrst_s_wren", {31'd0, s_wren}, 32'd0);
        chk("midrst_ct_wren", {31'd0, ct_wren}, 32'd0);
        chk("midrst_rdy", {31'd0, rdy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        start_dut(KV_KEY);
        wait_rdy("postrst");
        check_log("postrst", 10);

        // Randomized runs against the model
        for (int r = 0; r < 6; r++) begin
            rk  = 24'($urandom);
            len = (r == 5) ? 255 : $urandom_range(1, 20);
            pt_mem[0] = 8'(len);
            for (int x = 1; x < 256; x++) pt_mem[x] = 8'($urandom);
            start_dut(rk);
            wait_rdy($sformatf("rnd%0d", r));
            n = model_run(rk, 255);
            check_log($sformatf("rnd%0d", r), n);
            chk($sformatf("rnd%0d_pt_max", r), {31'd0, pt_max <= len}, 32'd1);
        end

        // Clamp with MAX_LEN=4
        load_kv();
        ct_log2.delete();
        pt_max2 = 0;
        @(negedge clk);
        key = KV_KEY;
        en2 = 1'b1;
        @(negedge clk);
        en2 = 1'b0;
        n = 0;
        while (!rdy2 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("clamp_done", {31'd0, rdy2}, 32'd1);
        chk("clamp_count", ct_log2.size(), 32'd5);
        for (int x = 0; x < 5 && x < ct_log2.size(); x++) begin
            chk($sformatf("clamp_addr%0d", x), {24'd0, ct_log2[x][15:8]}, x);
            chk($sformatf("clamp_data%0d", x), {24'd0, ct_log2[x][7:0]},
                (x == 0) ? 32'd4 : {24'd0, kv_ct[x]});
        end
        chk("clamp_pt_max", {31'd0, pt_max2 <= 4}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/arc4_encrypt.md
Name: arc4_encrypt

Overview:
- Streaming ARC4 encryptor: reads a length-prefixed plaintext from on-chip RAM, runs KSA + PRGA with a 24-bit key, and writes a length-prefixed ciphertext to a second RAM.
- It is the producer side of the cracking datapath: it generates the ciphertext images that the crack/decrypt cores consume.
- The S-box lives in an external 256x8 single-port RAM owned by the block while busy.
- Start/finish use the team's rdy/en handshake.

Parameters:
- KEY_BYTES, 3: key length in bytes; byte index is i mod KEY_BYTES.
- MAX_LEN, 255: largest message length accepted; a length byte above MAX_LEN is clamped to MAX_LEN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  high = idle and ready to accept en
- key  in  24  key; key[23:16] = key byte 0, key[7:0] = byte 2; latched on accepted en
- s_addr  out  8  S RAM address
- s_rddata  in  8  S RAM read data, 1-cycle synchronous latency
- s_wrdata  out  8  S RAM write data
- s_wren  out  1  S RAM write enable
- pt_addr  out  8  plaintext RAM address
- pt_rddata  in  8  plaintext read data, 1-cycle synchronous latency
- ct_addr  out  8  ciphertext RAM address
- ct_wrdata  out  8  ciphertext write data
- ct_wren  out  1  ciphertext write enable

Behaviour:
- Reset (async, any state): state IDLE, rdy=1, all wren=0, all addr/wrdata=0, i=j=k=0.
  - Reset mid-operation abandons the run. Partial RAM contents are undefined; no further writes occur.
- Handshake:
  - en accepted when rdy=1 on a rising edge. rdy=0 from the next cycle.
  - en while rdy=0 is ignored.
  - rdy returns to 1 the cycle after the final ct write.
  - en held high continuously restarts immediately after completion.
- All RAM addresses and indices are 8-bit; sums wrap mod 256.
- At most one S access per cycle (read or write).
- Read data is used exactly 1 cycle after its address is presented.
- States:
  - IDLE -> INIT on accepted en.
  - INIT: write S[a]=a for a=0..255, one per cycle, 256 cycles -> KSA.
  - KSA, for i=0..255:
    - read S[i];
    - j=j+S[i]+keybyte[i mod 3];
    - read S[j];
    - write S[i]=old S[j], then S[j]=old S[i].
    - i==j must leave S unchanged (use the latched values, not re-reads).
    - After i=255 -> LEN.
  - LEN:
    - read pt[0]; L = min(pt[0], MAX_LEN);
    - write ct[0]=L;
    - set i=j=0, k=1.
    - L==0 -> DONE.
  - PRGA, for k=1..L:
    - i=i+1; read S[i]; j=j+S[i]; read S[j];
    - swap S[i]/S[j] as in KSA;
    - read S[(S[i]+S[j]) mod 256] using post-swap values as pad;
    - read pt[k]; write ct[k]=pt[k] XOR pad.
    - After k=L -> DONE.
  - DONE: all wren=0, rdy=1, -> IDLE.
- ct writes:
  - exactly L+1 single-cycle pulses, at strictly increasing addresses 0..L;
  - no write to ct addresses above L.
- key changes while busy have no effect.
- pt is read-only, and only at addresses 0..L.

Test Plan:
- Known vector: key=24'h4B6579 ("Key"), pt={9,"Plaintext"} -> ct[0]=9, ct[1..9]=BB F3 16 E8 D9 40 AF 0A D3; rdy rises once after the 10th ct write.
- Zero length: pt[0]=0, any key -> exactly one ct write (addr 0, data 0), no pt reads above addr 0, rdy returns high.
- Round trip: encrypt pt={3,8'h00,8'h00,8'h00} with key=24'h000000, then feed the resulting ct back as pt with the same key -> output equals original {3,00,00,00}. The bytes 1..3 from the first run equal the key stream.
- Handshake: assert en mid-run and toggle key mid-run -> no restart; output identical to a clean run. Hold en high -> second run starts the cycle after rdy rises and produces identical ct.
- Reset mid-PRGA: pulse rst_n low during byte 4 of the "Plaintext" run -> all wren drop immediately, rdy=1. A fresh en reproduces the full correct vector.
- Clamp: MAX_LEN=4, pt[0]=9 with the "Plaintext" vector -> ct[0]=4, ct[1..4]=BB F3 16 E8, no write at ct[5].
